// File: rtl/ccff_loader_pkg.sv
// Shared types and default widths for the configuration-chain bitstream loader.
package ccff_loader_pkg;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_LEN_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ccff_word_serializer.sv
// Holds one bitstream word and walks it MSB first; reports the bit that follows
// the one currently on the chain head and whether the current bit is the word's last.
module ccff_word_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  output logic              next_bit,
  output logic              last
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] sreg;
  logic [CNT_W-1:0]  bits_left;

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      sreg      <= '0;
      bits_left <= '0;
    end else if (load) begin
      sreg      <= data;
      bits_left <= CNT_W'(WORD_W);
    end else if (shift) begin
      sreg      <= sreg << 1;
      bits_left <= bits_left - CNT_W'(1);
    end
  end

  // sreg[WORD_W-1] is the bit currently on the head, so the successor sits one below.
  assign next_bit = sreg[WORD_W-2];
  assign last     = (bits_left == CNT_W'(1));

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Streams a word-wide bitstream serially into a configuration flip-flop chain,
// counting exactly chain_len shifts and tracking the parity of the chain tail.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  chain_len,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic              cfg_done,
  output logic              busy,
  output logic              error,
  output logic              tail_parity,
  output state_t            dbg_state
);

  // Handshake: a word transfers on a rising edge where word_valid and word_ready
  // are both high; word_ready is high only in LOAD and word_valid may drop freely.

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             ser_load;
  logic             ser_shift;
  logic             next_bit;
  logic             word_last;

  assign ser_load  = word_valid & word_ready;
  assign ser_shift = (state == ST_SHIFT);
  assign dbg_state = state;

  ccff_word_serializer #(.WORD_W(WORD_W)) u_serializer (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .load       (ser_load),
    .shift      (ser_shift),
    .data       (word_data),
    .next_bit   (next_bit),
    .last       (word_last)
  );

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      word_ready  <= 1'b0;
      ccff_head   <= 1'b0;
      shift_en    <= 1'b0;
      cfg_done    <= 1'b0;
      busy        <= 1'b0;
      error       <= 1'b0;
      tail_parity <= 1'b0;
    end else begin
      error <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (chain_len != '0) begin
              state       <= ST_LOAD;
              remaining   <= chain_len;
              cfg_done    <= 1'b0;
              tail_parity <= 1'b0;
              word_ready  <= 1'b1;
              busy        <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (word_valid) begin
            state      <= ST_SHIFT;
            word_ready <= 1'b0;
            shift_en   <= 1'b1;
            ccff_head  <= word_data[WORD_W-1];
          end
        end
        ST_SHIFT: begin
          // The chain shifts on this edge, so the tail bit now present is counted.
          tail_parity <= tail_parity ^ ccff_tail;
          remaining   <= remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            state     <= ST_DONE;
            shift_en  <= 1'b0;
            ccff_head <= 1'b0;
            cfg_done  <= 1'b1;
            busy      <= 1'b0;
          end else if (word_last) begin
            state      <= ST_LOAD;
            shift_en   <= 1'b0;
            ccff_head  <= 1'b0;
            word_ready <= 1'b1;
          end else begin
            ccff_head <= next_bit;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
